pkt_rx_deframer: RTL

//  Receive side of the node packet interface; the counterpart of the reward/packet-composer block.

---
 rtl/eer_rl_pkg.sv | 44 ++++
 rtl/pkt_xor_acc.sv | 33 +++
 rtl/pkt_rx_deframer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/eer_rl_pkg.sv
// eer_rl_pkg: definitions shared by the packet composer and the receive deframer.
//  - packet type codes carried in header[2:0]
//  - header sync byte, broadcast ID, field word indices within a frame
//  - receive deframer state encoding
//  - hdr_ok(): header acceptance test (sync byte + legal type code)
package eer_rl_pkg;

  localparam int          WORD_WIDTH = 16;
  localparam logic [7:0]  HDR_SYNC   = 8'hA5;
  localparam logic [15:0] BCAST_ID   = 16'hFFFF;

  // Word positions of the fields in a frame (word 0 is the header).
  localparam int IDX_SRC    = 1;
  localparam int IDX_ENERGY = 2;
  localparam int IDX_QVAL   = 3;
  localparam int IDX_HOPS   = 4;
  localparam int IDX_DEST   = 5;
  localparam int IDX_CH     = 6;
  localparam int IDX_CHHOPS = 7;

  typedef enum logic [2:0] {
    PKT_HB    = 3'd1,
    PKT_CHE   = 3'd2,
    PKT_CINFO = 3'd3,
    PKT_DATA  = 3'd4,
    PKT_ACK   = 3'd5
  } pkt_type_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FIELDS = 3'd1,
    ST_CHECK  = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DRAIN  = 3'd4
  } rx_state_e;

  // Header is good when the sync byte matches and the type is one of HB..ACK.
  function automatic logic hdr_ok(input logic [7:0] sync_f,
                                  input logic [2:0] type_f,
                                  input logic [7:0] sync_ref);
    return (sync_f == sync_ref) && (type_f >= PKT_HB) && (type_f <= PKT_ACK);
  endfunction

endpackage

// File: rtl/pkt_xor_acc.sv
// pkt_xor_acc: running XOR of accepted packet words.
//  clk, rst : clock, async active-high reset
//  clr      : load din as the first word (header accept), discarding old state
//  en       : fold din into the running XOR
//  din      : word to load / fold
//  acc      : current XOR of all words since the last clr (inclusive)
module pkt_xor_acc #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] acc
);

  logic [WIDTH-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr)     acc_d = din;
    else if (en) acc_d = acc_q ^ din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/pkt_rx_deframer.sv
// pkt_rx_deframer: word-serial packet receiver. Checks the header, captures
// the seven field words into a shadow set and publishes them on the f* outputs
// only for a complete, well-formed frame; errored frames leave f* untouched.
//  clk, rst          : clock, async active-high reset
//  myNodeID          : this node's ID, compared against the destination field
//  in_valid/in_word/in_last/in_ready : word stream, accepted on valid && ready
//  fPacketType..fHopsFromCH, iAmDestination : fields of the last good packet
//  pkt_valid         : one-cycle pulse when the f* outputs update
//  pkt_err           : one-cycle pulse when a frame is discarded
// Build option: define RX_CHECKSUM_EN to require a 9th word equal to the XOR
// of words 0..7.
module pkt_rx_deframer
  import eer_rl_pkg::*;
#(
  parameter int                    WORD_WIDTH = eer_rl_pkg::WORD_WIDTH,
  parameter logic [7:0]            HDR_SYNC   = eer_rl_pkg::HDR_SYNC,
  parameter logic [WORD_WIDTH-1:0] BCAST_ID   = eer_rl_pkg::BCAST_ID
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic                  in_valid,
  input  logic [WORD_WIDTH-1:0] in_word,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [2:0]            fPacketType,
  output logic [WORD_WIDTH-1:0] fSourceID,
  output logic [WORD_WIDTH-1:0] fEnergyLeft,
  output logic [WORD_WIDTH-1:0] fQValue,
  output logic [WORD_WIDTH-1:0] fSourceHops,
  output logic [WORD_WIDTH-1:0] fDestinationID,
  output logic [WORD_WIDTH-1:0] fChosenCH,
  output logic [WORD_WIDTH-1:0] fHopsFromCH,
  output logic                  iAmDestination,
  output logic                  pkt_valid,
  output logic                  pkt_err
);

  rx_state_e                   state_q, state_d;
  logic [2:0]                  idx_q, idx_d;
  logic [2:0]                  type_q, type_d;
  logic [7:1][WORD_WIDTH-1:0]  shadow_q, shadow_d;
  logic [2:0]                  ftype_q, ftype_d;
  logic [7:1][WORD_WIDTH-1:0]  fld_q, fld_d;
  logic                        iam_q, iam_d;
  logic                        pkt_valid_q, pkt_valid_d;
  logic                        pkt_err_q, pkt_err_d;
  logic                        accept;
  logic                        commit;

  assign in_ready = (state_q != ST_COMMIT);
  assign accept   = in_valid && in_ready;

`ifdef RX_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] xor_acc;

  // Header accept restarts the XOR; every field word is folded in.
  pkt_xor_acc #(.WIDTH(WORD_WIDTH)) u_xor_acc (
    .clk (clk),
    .rst (rst),
    .clr (accept && (state_q == ST_IDLE)),
    .en  (accept && (state_q == ST_FIELDS)),
    .din (in_word),
    .acc (xor_acc)
  );
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    type_d      = type_q;
    shadow_d    = shadow_q;
    ftype_d     = ftype_q;
    fld_d       = fld_q;
    iam_d       = iam_q;
    pkt_valid_d = 1'b0;
    pkt_err_d   = 1'b0;
    commit      = 1'b0;

    case (state_q)
      ST_IDLE: if (accept) begin
        if (hdr_ok(in_word[WORD_WIDTH-1 -: 8], in_word[2:0], HDR_SYNC) && !in_last) begin
          state_d = ST_FIELDS;
          idx_d   = 3'd1;
          type_d  = in_word[2:0];
        end else if (in_last) begin
          pkt_err_d = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end

      ST_FIELDS: if (accept) begin
        shadow_d[idx_q] = in_word;
        if (idx_q != 3'd7) begin
          if (in_last) begin
            state_d   = ST_IDLE;
            idx_d     = 3'd0;
            pkt_err_d = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          idx_d = 3'd0;
`ifdef RX_CHECKSUM_EN
          if (in_last) begin
            state_d   = ST_IDLE;
            pkt_err_d = 1'b1;
          end else begin
            state_d = ST_CHECK;
          end
`else
          if (in_last) commit  = 1'b1;
          else         state_d = ST_DRAIN;
`endif
        end
      end

      ST_CHECK: begin
`ifdef RX_CHECKSUM_EN
        if (accept) begin
          if ((in_word == xor_acc) && in_last) begin
            commit = 1'b1;
          end else if (in_word != xor_acc) begin
            pkt_err_d = 1'b1;
            state_d   = in_last ? ST_IDLE : ST_DRAIN;
          end else begin
            // Checksum matched but the frame keeps going: overrun.
            state_d = ST_DRAIN;
          end
        end
`else
        state_d = ST_IDLE;
`endif
      end

      ST_COMMIT: state_d = ST_IDLE;

      ST_DRAIN: if (accept && in_last) begin
        state_d   = ST_IDLE;
        pkt_err_d = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase

    // Outputs are loaded on the edge that enters COMMIT, from the shadow set
    // including the word accepted on that same edge, so they are already
    // valid during the COMMIT cycle that carries pkt_valid.
    if (commit) begin
      state_d     = ST_COMMIT;
      pkt_valid_d = 1'b1;
      ftype_d     = type_d;
      fld_d       = shadow_d;
      iam_d       = (shadow_d[IDX_DEST] == myNodeID) || (shadow_d[IDX_DEST] == BCAST_ID);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      type_q      <= '0;
      shadow_q    <= '0;
      ftype_q     <= '0;
      fld_q       <= '0;
      iam_q       <= 1'b0;
      pkt_valid_q <= 1'b0;
      pkt_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      type_q      <= type_d;
      shadow_q    <= shadow_d;
      ftype_q     <= ftype_d;
      fld_q       <= fld_d;
      iam_q       <= iam_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_err_q   <= pkt_err_d;
    end
  end

  assign fPacketType    = ftype_q;
  assign fSourceID      = fld_q[IDX_SRC];
  assign fEnergyLeft    = fld_q[IDX_ENERGY];
  assign fQValue        = fld_q[IDX_QVAL];
  assign fSourceHops    = fld_q[IDX_HOPS];
  assign fDestinationID = fld_q[IDX_DEST];
  assign fChosenCH      = fld_q[IDX_CH];
  assign fHopsFromCH    = fld_q[IDX_CHHOPS];
  assign iAmDestination = iam_q;
  assign pkt_valid      = pkt_valid_q;
  assign pkt_err        = pkt_err_q;

endmodule
